// File: rtl/fetch_stall_controller.sv
// Fetch front-end sequencer around the IF/ID register.
// It produces the PC and IF/ID enables from the cache hit, the branch redirect
// and the load-use hazard. On an I-cache miss it refills one line with a
// req/ack handshake and counts the miss.
module fetch_stall_controller #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 hit,
    input  logic [31:0]          fetchAddr,
    input  logic                 branchTaken,
    input  logic                 loadUseHazard,
    input  logic                 memAck,
    output logic                 memReq,
    output logic [31:0]          memAddr,
    output logic                 refillWe,
    output logic [IDX_W-1:0]     refillIdx,
    output logic                 pcWrite,
    output logic                 ifidWrite,
    output logic                 ifidFlush,
    output logic [CNT_WIDTH-1:0] missCount
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    // Byte-offset bits inside one line (word index plus the 2-bit byte offset).
    localparam int               OFF_W     = IDX_W + 2;
    localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LINE_WORDS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t                 state_r;
    logic [31:0]            line_base_r;
    logic [IDX_W-1:0]       refill_idx_r;
    logic [CNT_WIDTH-1:0]   miss_count_r;

    logic                   miss_start_s;
    logic                   ack_s;

    // Refill word address: line base plus the current word index in bytes.
    assign memAddr   = line_base_r + {{(30 - IDX_W){1'b0}}, refill_idx_r, 2'b00};
    assign refillIdx = refill_idx_r;
    assign missCount = miss_count_r;

    // Front-end controls and refill handshake; Reset forces IF/ID to be cleared.
    always_comb begin
        pcWrite      = 1'b0;
        ifidWrite    = 1'b1;
        ifidFlush    = 1'b1;
        memReq       = 1'b0;
        refillWe     = 1'b0;
        miss_start_s = 1'b0;
        ack_s        = 1'b0;
        if (Reset) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b1;
            ifidFlush = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (branchTaken) begin
                        // Wrong-path fetch is squashed; any miss on it is irrelevant.
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        ifidFlush = 1'b1;
                    end else if (loadUseHazard) begin
                        // Hold everything; the same PC is looked up again next cycle.
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        ifidFlush = 1'b0;
                    end else if (!hit) begin
                        // ID advances, a bubble enters, refill starts next cycle.
                        pcWrite      = 1'b0;
                        ifidWrite    = 1'b1;
                        ifidFlush    = 1'b1;
                        miss_start_s = 1'b1;
                    end else begin
                        pcWrite   = 1'b1;
                        ifidWrite = 1'b1;
                        ifidFlush = 1'b0;
                    end
                end
                ST_REFILL: begin
                    memReq   = 1'b1;
                    refillWe = memAck;
                    ack_s    = memAck;
                end
                ST_RESUME: begin
                    memReq = 1'b0;
                end
                default: begin
                    memReq = 1'b0;
                end
            endcase
        end
    end

    // State, line base, word index and saturating miss counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_RUN;
            line_base_r  <= 32'd0;
            refill_idx_r <= '0;
            miss_count_r <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (miss_start_s) begin
                        line_base_r  <= fetchAddr & LINE_MASK;
                        refill_idx_r <= '0;
                        if (miss_count_r != CNT_MAX) begin
                            miss_count_r <= miss_count_r + CNT_WIDTH'(1);
                        end
                        state_r <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (ack_s) begin
                        if (refill_idx_r == LAST_IDX) begin
                            refill_idx_r <= '0;
                            state_r      <= ST_RESUME;
                        end else begin
                            refill_idx_r <= refill_idx_r + IDX_W'(1);
                        end
                    end
                end
                ST_RESUME: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

endmodule
